// File: rtl/scarv_uart_pkg.sv
// Shared definitions for the SCARV UART receive and transmit blocks.
//   uart_rx_state_e : receiver FSM states
//   uart_cpb()      : clock cycles per line bit
//   uart_half()     : clock cycles to the middle of a bit
//   UART_DATA_W     : character width in bits
package scarv_uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } uart_rx_state_e;

    function automatic int unsigned uart_cpb(input int unsigned clk_hz,
                                             input int unsigned bit_rate);
        return clk_hz / bit_rate;
    endfunction

    function automatic int unsigned uart_half(input int unsigned cpb);
        return cpb / 2;
    endfunction

endpackage

// File: rtl/scarv_uart_rx_fifo.sv
// Synchronous first-word fall-through FIFO.
//   f_clk, sys_reset : clock, asynchronous active-low reset
//   push, push_data  : write request and data (ignored when full unless popping)
//   pop              : read request (ignored when empty)
//   pop_data         : head entry, valid while !empty
//   full, empty      : occupancy flags
module scarv_uart_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             f_clk,
    input  logic             sys_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // One extra pointer bit separates full from empty when the indices match.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot being written.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge f_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/scarv_uart_rx.sv
// UART receiver: deserialises 8N1/8N2 frames from uart_rxd into a byte FIFO.
//   f_clk, sys_reset : clock, asynchronous active-low reset
//   uart_rxd         : asynchronous serial input, idles high
//   rx_valid/rx_data : FIFO head byte, accepted when rx_ready is high
//   rx_busy          : receiver is inside a frame (or waiting out a break)
//   rx_frame_err     : one-cycle pulse, a stop bit was sampled low
//   rx_overrun       : one-cycle pulse, a completed byte was dropped (FIFO full)
module scarv_uart_rx
    import scarv_uart_pkg::*;
#(
    parameter int unsigned UART_BIT_RATE  = 115200,
    parameter int unsigned UART_CLK_HZ    = 50_000_000,
    parameter int unsigned UART_STOP_BITS = 1,
    parameter int unsigned RX_FIFO_DEPTH  = 4
) (
    input  logic                   f_clk,
    input  logic                   sys_reset,
    input  logic                   uart_rxd,
    output logic                   rx_valid,
    output logic [UART_DATA_W-1:0] rx_data,
    input  logic                   rx_ready,
    output logic                   rx_busy,
    output logic                   rx_frame_err,
    output logic                   rx_overrun
);

    localparam int unsigned CPB  = uart_cpb(UART_CLK_HZ, UART_BIT_RATE);
    localparam int unsigned HALF = uart_half(CPB);
    localparam int unsigned CW   = (CPB > 1) ? $clog2(CPB) : 1;

    localparam logic [CW-1:0] CPB_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic          LAST_STOP = (UART_STOP_BITS == 2);
    localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_W - 1);

    logic                   rxd_meta_q;
    logic                   rxs;
    uart_rx_state_e         state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic                   stop_idx_q, stop_idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   push;
    logic                   fifo_full;
    logic                   fifo_empty;

    // Two-flop synchroniser; flops reset to the idle line level.
    always_ff @(posedge f_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            rxd_meta_q <= 1'b1;
            rxs        <= 1'b1;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxs        <= rxd_meta_q;
        end
    end

    always_ff @(posedge f_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            stop_idx_q  <= stop_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                // Mid-start-bit check; a line already back high was a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rxs ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == CPB_LAST) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rxs;
                    bit_idx_d          = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_BIT) begin
                        stop_idx_d = 1'b0;
                        state_d    = StStop;
                    end
                end
            end
            StStop: begin
                if (cnt_q == CPB_LAST) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end else if (stop_idx_q == LAST_STOP) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            StBreak: begin
                // Hold off until the line releases so a stuck-low line is one error.
                cnt_d = '0;
                if (rxs) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // A full FIFO always holds a head byte, so rx_ready alone decides the pop.
    assign overrun_d = push && fifo_full && !rx_ready;

    scarv_uart_rx_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_fifo (
        .f_clk     (f_clk),
        .sys_reset (sys_reset),
        .push      (push),
        .push_data (shift_q),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rx_valid     = !fifo_empty;
    assign rx_busy      = (state_q != StIdle);
    assign rx_frame_err = frame_err_q;
    assign rx_overrun   = overrun_q;

endmodule

// File: tb/tb_scarv_uart_rx.sv
// Bench for scarv_uart_rx: three receivers (default rate; fast rate with one
// stop bit; fast rate with two stop bits), each driven by its own serial line.
module tb_scarv_uart_rx;

    localparam int NDUT      = 3;
    localparam int FAST_CLK  = 1_600_000;
    localparam int FAST_RATE = 100_000;
    localparam int DEPTH     = 4;

    logic       f_clk = 1'b0;
    logic       sys_reset;
    logic       rxd   [NDUT];
    logic       ready [NDUT];
    logic       valid [NDUT];
    logic [7:0] data  [NDUT];
    logic       busy  [NDUT];
    logic       ferr  [NDUT];
    logic       ovr   [NDUT];

    int         cpb_of   [NDUT];
    int         nstop_of [NDUT];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] got_q [NDUT][$];
    logic [7:0] exp_q [NDUT][$];
    int         rd_idx [NDUT];
    int         fe_cnt [NDUT];
    int         ov_cnt [NDUT];

    always #5 f_clk = ~f_clk;

    scarv_uart_rx u_dut_def (
        .f_clk (f_clk), .sys_reset (sys_reset), .uart_rxd (rxd[0]),
        .rx_valid (valid[0]), .rx_data (data[0]), .rx_ready (ready[0]),
        .rx_busy (busy[0]), .rx_frame_err (ferr[0]), .rx_overrun (ovr[0])
    );

    scarv_uart_rx #(
        .UART_BIT_RATE (FAST_RATE), .UART_CLK_HZ (FAST_CLK),
        .UART_STOP_BITS (1), .RX_FIFO_DEPTH (DEPTH)
    ) u_dut_fast (
        .f_clk (f_clk), .sys_reset (sys_reset), .uart_rxd (rxd[1]),
        .rx_valid (valid[1]), .rx_data (data[1]), .rx_ready (ready[1]),
        .rx_busy (busy[1]), .rx_frame_err (ferr[1]), .rx_overrun (ovr[1])
    );

    scarv_uart_rx #(
        .UART_BIT_RATE (FAST_RATE), .UART_CLK_HZ (FAST_CLK),
        .UART_STOP_BITS (2), .RX_FIFO_DEPTH (DEPTH)
    ) u_dut_two (
        .f_clk (f_clk), .sys_reset (sys_reset), .uart_rxd (rxd[2]),
        .rx_valid (valid[2]), .rx_data (data[2]), .rx_ready (ready[2]),
        .rx_busy (busy[2]), .rx_frame_err (ferr[2]), .rx_overrun (ovr[2])
    );

    // Mid-cycle monitor: a byte is consumed whenever valid and ready are both high.
    always @(negedge f_clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (valid[i] && ready[i]) got_q[i].push_back(data[i]);
            if (ferr[i]) fe_cnt[i]++;
            if (ovr[i]) ov_cnt[i]++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge f_clk);
        #1;
    endtask

    // Start bit, 8 data bits LSB first, then the stop bits; bad_stop drives the last one low.
    task automatic send_frame(input int i, input logic [7:0] d, input logic bad_stop);
        logic [10:0] bits;
        int          n;
        n    = 9 + nstop_of[i];
        bits = {2'b11, d, 1'b0};
        if (bad_stop) bits[n-1] = 1'b0;
        for (int b = 0; b < n; b++) begin
            rxd[i] = bits[b];
            repeat (cpb_of[i]) tick();
        end
    endtask

    task automatic compare_rx(input int i, input string tag);
        check({tag, "_count"}, got_q[i].size() - rd_idx[i], exp_q[i].size());
        for (int k = 0; k < exp_q[i].size(); k++) begin
            if (rd_idx[i] + k < got_q[i].size())
                check({tag, "_byte"}, got_q[i][rd_idx[i] + k], exp_q[i][k]);
        end
        rd_idx[i] = got_q[i].size();
        exp_q[i].delete();
    endtask

    // Cycles from driving the start edge until rx_valid is first seen.
    task automatic frame_latency(input int i, input logic [7:0] d, output int lat);
        int bound;
        int l;
        bound = 4 + cpb_of[i] / 2 + 9 * cpb_of[i];
        l     = -1;
        fork
            send_frame(i, d, 1'b0);
            begin
                for (int c = 1; c <= bound + 8; c++) begin
                    tick();
                    if (valid[i] && l < 0) l = c;
                end
            end
        join
        lat = l;
        check("latency_in_bound", int'(l > 0 && l <= bound), 1);
    endtask

    initial begin
        int         lat0;
        int         lat1;
        int         fe0;
        int         ov0;
        int         occ;
        int         exp_ov;
        logic [7:0] b;

        cpb_of   = '{50_000_000 / 115_200, FAST_CLK / FAST_RATE, FAST_CLK / FAST_RATE};
        nstop_of = '{1, 1, 2};
        for (int i = 0; i < NDUT; i++) begin
            rxd[i]   = 1'b1;
            ready[i] = 1'b0;
            rd_idx[i] = 0;
        end
        sys_reset = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < NDUT; i++) begin
            check("rst_valid", valid[i], 0);
            check("rst_data", data[i], 0);
            check("rst_busy", busy[i], 0);
            check("rst_ferr", ferr[i], 0);
            check("rst_ovr", ovr[i], 0);
        end
        sys_reset = 1'b1;
        repeat (3) tick();

        // Default rate, 0x55 with the consumer always ready.
        ready[0] = 1'b1;
        frame_latency(0, 8'h55, lat0);
        exp_q[0].push_back(8'h55);
        repeat (5) tick();
        compare_rx(0, "f55");
        check("f55_ferr", fe_cnt[0], 0);

        // Default rate, 100-cycle low glitch is rejected.
        fe0 = fe_cnt[0];
        rxd[0] = 1'b0;
        repeat (100) tick();
        rxd[0] = 1'b1;
        repeat (300) tick();
        check("glitch_busy", busy[0], 0);
        repeat (11 * cpb_of[0]) tick();
        compare_rx(0, "glitch");
        check("glitch_ferr", fe_cnt[0] - fe0, 0);

        // Fast rate: calibrate the start-edge-to-valid latency with a random byte.
        ready[1] = 1'b1;
        b = 8'($urandom);
        frame_latency(1, b, lat1);
        exp_q[1].push_back(b);
        repeat (3) tick();
        compare_rx(1, "calib");

        // Short glitch, below half a bit.
        rxd[1] = 1'b0;
        repeat ($urandom_range(1, 5)) tick();
        rxd[1] = 1'b1;
        repeat (100) tick();
        check("short_glitch_busy", busy[1], 0);
        compare_rx(1, "short_glitch");

        // 0xA3 with a low stop bit, line then held low for 20 bit times.
        fe0 = fe_cnt[1];
        send_frame(1, 8'hA3, 1'b1);
        repeat (20 * cpb_of[1]) tick();
        check("break_busy_low", busy[1], 1);
        check("break_valid", valid[1], 0);
        rxd[1] = 1'b1;
        repeat (5) tick();
        check("break_busy_high", busy[1], 0);
        check("break_ferr", fe_cnt[1] - fe0, 1);
        compare_rx(1, "break");

        // Six frames, consumer stalled: FIFO keeps the first DEPTH, the rest overrun.
        ready[1] = 1'b0;
        ov0      = ov_cnt[1];
        occ      = 0;
        exp_ov   = 0;
        for (int k = 1; k <= 6; k++) begin
            send_frame(1, 8'(k), 1'b0);
            if (occ < DEPTH) begin
                exp_q[1].push_back(8'(k));
                occ++;
            end else begin
                exp_ov++;
            end
        end
        repeat (3) tick();
        check("ovr_pulses", ov_cnt[1] - ov0, exp_ov);
        check("ovr_valid", valid[1], 1);
        check("ovr_head", data[1], 8'h01);
        check("ovr_nothing_popped", got_q[1].size() - rd_idx[1], 0);
        ready[1] = 1'b1;
        repeat (8) tick();
        ready[1] = 1'b0;
        compare_rx(1, "ovr_drain");

        // Full FIFO, fifth byte lands in the cycle the consumer pops the head.
        ov0 = ov_cnt[1];
        for (int k = 1; k <= DEPTH; k++) begin
            send_frame(1, 8'(k), 1'b0);
            exp_q[1].push_back(8'(k));
        end
        fork
            send_frame(1, 8'h7E, 1'b0);
            begin
                repeat (lat1 - 1) tick();
                ready[1] = 1'b1;
                tick();
                ready[1] = 1'b0;
            end
        join
        exp_q[1].push_back(8'h7E);
        repeat (3) tick();
        check("same_cycle_ovr", ov_cnt[1] - ov0, 0);
        check("same_cycle_one_pop", got_q[1].size() - rd_idx[1], 1);
        ready[1] = 1'b1;
        repeat (8) tick();
        compare_rx(1, "same_cycle_drain");

        // Random bytes with random idle gaps, consumer always ready.
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            send_frame(1, b, 1'b0);
            exp_q[1].push_back(b);
            repeat ($urandom_range(0, 20)) tick();
        end
        repeat (3) tick();
        compare_rx(1, "rand_fast");

        // Two stop bits: a clean frame, then 0xC3 with the second stop bit low.
        ready[2] = 1'b1;
        b = 8'($urandom);
        send_frame(2, b, 1'b0);
        exp_q[2].push_back(b);
        repeat (3) tick();
        compare_rx(2, "two_stop_ok");
        fe0 = fe_cnt[2];
        send_frame(2, 8'hC3, 1'b1);
        rxd[2] = 1'b1;
        repeat (5) tick();
        check("two_stop_ferr", fe_cnt[2] - fe0, 1);
        check("two_stop_busy", busy[2], 0);
        compare_rx(2, "two_stop_bad");

        // Reset in the middle of the data bits.
        rxd[2] = 1'b0;
        repeat (cpb_of[2]) tick();
        for (int k = 0; k < 3; k++) begin
            rxd[2] = k[0];
            repeat (cpb_of[2]) tick();
        end
        check("mid_busy", busy[2], 1);
        sys_reset = 1'b0;
        #1;
        check("mid_rst_busy", busy[2], 0);
        check("mid_rst_valid", valid[2], 0);
        check("mid_rst_data", data[2], 0);
        check("mid_rst_ferr", ferr[2], 0);
        rxd[2] = 1'b1;
        repeat (3) tick();
        sys_reset = 1'b1;
        repeat (40) tick();
        check("post_rst_busy", busy[2], 0);
        compare_rx(2, "post_rst_none");
        send_frame(2, 8'h5A, 1'b0);
        exp_q[2].push_back(8'h5A);
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            send_frame(2, b, 1'b0);
            exp_q[2].push_back(b);
        end
        repeat (3) tick();
        compare_rx(2, "post_rst_rx");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
